// File: rtl/alu_pkg.sv
// Shared definitions for alu_md_unit: operation codes, handshake FSM states and
// the fill value returned for illegal operation codes.
package alu_pkg;

  localparam logic [3:0] OpAnd   = 4'b0000;
  localparam logic [3:0] OpOr    = 4'b0001;
  localparam logic [3:0] OpAdd   = 4'b0010;
  localparam logic [3:0] OpSub   = 4'b0011;
  localparam logic [3:0] OpXor   = 4'b0100;
  localparam logic [3:0] OpNor   = 4'b0101;
  localparam logic [3:0] OpSlt   = 4'b0110;
  localparam logic [3:0] OpSltu  = 4'b0111;
  localparam logic [3:0] OpMultu = 4'b1000;
  localparam logic [3:0] OpDivu  = 4'b1001;
  localparam logic [3:0] OpMfhi  = 4'b1010;
  localparam logic [3:0] OpMflo  = 4'b1011;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Replicated across the datapath width to form the illegal-op result.
  localparam logic IllegalResultBit = 1'b0;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one step per
// step_i cycle for Width steps. hi_o/lo_o present the post-step values for capture on done_o.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             step_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int unsigned CntW = $clog2(Width) + 1;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             div_q, div_d;
  logic [Width-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [Width:0]   mul_sum, rem_shift, rem_sub;

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(Width + 1){1'b0}});
    rem_shift = {hi_q, lo_q[Width-1]};
    rem_sub   = rem_shift - {1'b0, b_q};
    if (start_i) begin
      cnt_d = CntW'(Width - 1);
      div_d = div_i;
      hi_d  = '0;
      // lo holds the multiplier or dividend; b holds the multiplicand or divisor.
      lo_d  = div_i ? a_i : b_i;
      b_d   = div_i ? b_i : a_i;
    end else if (step_i) begin
      if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
      if (div_q) begin
        if (rem_shift >= {1'b0, b_q}) begin
          hi_d = rem_sub[Width-1:0];
          lo_d = {lo_q[Width-2:0], 1'b1};
        end else begin
          hi_d = rem_shift[Width-1:0];
          lo_d = {lo_q[Width-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {mul_sum, lo_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      div_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
    end
  end

  assign done_o = step_i && (cnt_q == '0);
  assign hi_o   = hi_d;
  assign lo_o   = lo_d;

endmodule

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with valid/ready result handshake. Define ALU_MULDIV_EN to build the
// iterative MULTU/DIVU engine and HI/LO registers; otherwise those codes are illegal.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             accept;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] single_res;

`ifdef ALU_MULDIV_EN
  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic             eng_start, eng_step, eng_done;
  logic             is_mul, is_div;
`endif

  always_comb begin
    single_res = {WIDTH{IllegalResultBit}};
    unique case (alu_control)
      OpAnd:   single_res = operand1 & operand2;
      OpOr:    single_res = operand1 | operand2;
      OpAdd:   single_res = operand1 + operand2;
      OpSub:   single_res = operand1 - operand2;
      OpXor:   single_res = operand1 ^ operand2;
      OpNor:   single_res = ~(operand1 | operand2);
      OpSlt:   single_res = WIDTH'($signed(operand1) < $signed(operand2));
      OpSltu:  single_res = WIDTH'(operand1 < operand2);
`ifdef ALU_MULDIV_EN
      OpMfhi:  single_res = hi_q;
      OpMflo:  single_res = lo_q;
`endif
      default: single_res = {WIDTH{IllegalResultBit}};
    endcase
  end

`ifdef ALU_MULDIV_EN
  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_control == OpMultu);
  assign is_div   = (alu_control == OpDivu);

  alu_iter_muldiv #(
    .Width(WIDTH)
  ) u_engine (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .start_i(eng_start),
    .div_i  (is_div),
    .step_i (eng_step),
    .a_i    (operand1),
    .b_i    (operand2),
    .done_o (eng_done),
    .hi_o   (eng_hi),
    .lo_o   (eng_lo)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    eng_start   = 1'b0;
    eng_step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul || (is_div && operand2 != '0)) begin
            state_d   = StBusy;
            eng_start = 1'b1;
          end else if (is_div) begin
            // Divide by zero skips the engine and completes straight away.
            state_d     = StDone;
            hi_d        = operand1;
            lo_d        = '1;
            result_d    = '1;
            zero_d      = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            result_d    = single_res;
            zero_d      = (single_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      StBusy: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          eng_step = 1'b1;
          if (eng_done) begin
            state_d     = StDone;
            hi_d        = eng_hi;
            lo_d        = eng_lo;
            result_d    = eng_lo;
            zero_d      = (eng_lo == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign in_ready     = 1'b1;
  assign accept       = in_valid;

  always_comb begin
    out_valid_d = accept;
    result_d    = result_q;
    zero_d      = zero_q;
    if (accept) begin
      result_d = single_res;
      zero_d   = (single_res == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
    end
  end

  assign hi = '0;
  assign lo = '0;
`endif

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign zero       = zero_q;

endmodule

// File: doc/alu_md_unit.md
# alu_md_unit

Parametrised execute-stage ALU for the pipelined MIPS core, successor to the 2-bit-control combinational ALU. It supports a wider operation set and a configurable datapath width, and it flags zero on every operation. It also adds an iterative unsigned multiply/divide engine with architectural HI/LO registers. Results return through a valid/ready handshake, so the hazard unit can stall the pipeline while a multi-cycle operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must be ≥ 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- alu_control  in  4  operation code (see Operation).
- operand1  in  WIDTH  first operand / dividend / multiplicand.
- operand2  in  WIDTH  second operand / divisor / multiplier.
- flush  in  1  synchronous abort of any in-flight multi-cycle operation.
- out_valid  out  1  one-cycle pulse; result and zero are valid.
- alu_result  out  WIDTH  registered result.
- zero  out  1  set when alu_result == 0, for every operation.
- hi  out  WIDTH  HI register (remainder / upper product).
- lo  out  WIDTH  LO register (quotient / lower product).

## Operation
- Codes: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 NOR, 0110 SLT (signed, result 0 or 1), 0111 SLTU, 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO.
- Codes 1100–1111 are illegal: result 0, zero 1, single cycle.
- ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
- Request accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready = 1.
  - BUSY: in_ready = 0; iterate for WIDTH cycles.
  - DONE: in_ready = 0; out_valid = 1; return to IDLE.
- Single-cycle ops (including MFHI/MFLO): result is registered on the accept edge; out_valid is high the next cycle; state stays IDLE, so back-to-back throughput is 1 op/cycle.
- MULTU: shift-add over WIDTH iterations giving a 2·WIDTH-bit product. On entry to DONE, {hi,lo} = product and alu_result = lo.
- DIVU: restoring division over WIDTH iterations. On entry to DONE, lo = quotient, hi = remainder, alu_result = quotient.
- Divide by zero: no iteration; next cycle the unit enters DONE with lo = all-ones, hi = operand1, alu_result = all-ones.
- MFHI/MFLO accepted in the cycle after a DONE return the updated hi/lo.
- flush in BUSY: return to IDLE on that edge; no out_valid; hi/lo unchanged.
- flush in IDLE or DONE has no effect; a DONE result is still delivered.
- in_valid is ignored while in_ready = 0; the requester must hold its request.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, alu_result 0, zero 1, hi 0, lo 0, iteration counter 0.
- Latency, accept to out_valid:
  - single-cycle ops: 1 cycle.
  - MULTU/DIVU: WIDTH+1 cycles (WIDTH in BUSY, then DONE).
  - DIVU by zero: 1 cycle.
- in_ready deasserts the cycle after a MULTU/DIVU accept and reasserts the cycle after DONE.
- The iteration counter is $clog2(WIDTH)+1 bits, loaded with WIDTH-1 at accept. BUSY exits when the counter reaches 0; there is no wrap.
- Reset asserted mid-operation immediately forces reset values; the in-flight result is lost.
- zero and alu_result change only on out_valid cycles and otherwise hold.

## Configuration
- ALU_MULDIV_EN defined: full behaviour as above.
- ALU_MULDIV_EN undefined:
  - codes 1000–1011 become illegal (result 0, zero 1, 1 cycle);
  - the engine, BUSY/DONE states and counter are not built;
  - in_ready is tied to 1; flush is ignored; hi and lo are tied to 0.

## Structure
- Shared package alu_pkg holds:
  - the 4-bit operation code localparams;
  - the state enum (IDLE, BUSY, DONE);
  - the illegal-op result constant.
- One sub-module, alu_iter_muldiv:
  - contains the iterative shift-add/restoring engine and counter, with start/op/done interface;
  - is instantiated only under ALU_MULDIV_EN.
- The top level contains the handshake FSM, the single-cycle op mux, and the HI/LO and result registers.

## Test plan
- Reset: drive rst_n low mid-cycle → outputs are at reset values immediately; in_ready = 1, zero = 1.
- Back-to-back SUB 5−5, ADD 0xFFFFFFFF+1, SLT −1<1 on consecutive cycles → results 0/zero 1, 0/zero 1, 1/zero 0 on three consecutive out_valid pulses.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - in_ready low for 33 cycles;
  - out_valid 33 cycles after accept with hi = 0xFFFFFFFE, lo = 0x00000001.
  - MFHI issued next → 0xFFFFFFFE.
- DIVU 100÷7 → lo = 14, hi = 2, out_valid at +33. DIVU 9÷0 → out_valid at +1, lo = 0xFFFFFFFF, hi = 9.
- flush 10 cycles into DIVU → in_ready high the next cycle, no out_valid, hi/lo keep prior values.
- Build without ALU_MULDIV_EN, issue MULTU 3×4 → 1-cycle result 0 with zero = 1; in_ready never drops.
